// File: rtl/if_id_prefetch_queue.sv
// Instruction prefetch queue between fetch and decode.
// Buffers {pc, instr} pairs in a small circular register array; the oldest
// pair is presented to decode with a valid/ready handshake. A flush (branch
// taken) or reset empties the queue in a single cycle.
module if_id_prefetch_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [31:0]   in_pc,
    input  logic [31:0]   in_instr,
    output logic          in_ready,
    output logic          out_valid,
    output logic [31:0]   out_pc,
    output logic [31:0]   out_instr,
    input  logic          out_ready,
    output logic [AW:0]   count
);

    localparam int unsigned CW = AW + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    entry_t        head;

    // Handshake qualifiers; in_ready looks only at occupancy, never at out_ready.
    always_comb begin
        in_ready  = (count < CW'(DEPTH));
        out_valid = (count != '0);
        push      = in_valid & in_ready & ~flush & ~reset;
        pop       = out_valid & out_ready & ~flush & ~reset;
    end

    // Head entry presented to decode; zeroed while the queue is empty.
    always_comb begin
        head      = mem[rd_ptr];
        out_pc    = '0;
        out_instr = '0;
        if (out_valid) begin
            out_pc    = head.pc;
            out_instr = head.instr;
        end
    end

    // Storage write; contents are left alone by flush/reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{pc: in_pc, instr: in_instr};
        end
    end

    // Pointers and occupancy; reset and flush both return the queue to empty.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_if_id_prefetch_queue.sv
// Testbench for if_id_prefetch_queue: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_if_id_prefetch_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic [31:0]   in_pc;
    logic [31:0]   in_instr;
    logic          in_ready;
    logic          out_valid;
    logic [31:0]   out_pc;
    logic [31:0]   out_instr;
    logic          out_ready;
    logic [AW:0]   count;

    int checks = 0;
    int errors = 0;

    logic [63:0] model_q[$];
    logic [31:0] next_pc;

    if_id_prefetch_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .out_ready (out_ready),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare DUT outputs against the model's current contents.
    task automatic compare_outputs();
        int n;
        n = model_q.size();
        check("count", 64'(count), 64'(n));
        check("in_ready", 64'(in_ready), 64'(n < DEPTH));
        check("out_valid", 64'(out_valid), 64'(n != 0));
        check("out_pc", 64'(out_pc), (n != 0) ? 64'(model_q[0][63:32]) : 64'd0);
        check("out_instr", 64'(out_instr), (n != 0) ? 64'(model_q[0][31:0]) : 64'd0);
    endtask

    // Drive one cycle of inputs, check outputs, then advance model past the edge.
    task automatic step(input bit rst, input bit fl, input bit iv,
                        input logic [31:0] pc, input logic [31:0] ins, input bit ordy);
        bit do_push;
        bit do_pop;
        reset     = rst;
        flush     = fl;
        in_valid  = iv;
        in_pc     = pc;
        in_instr  = ins;
        out_ready = ordy;
        #1;
        compare_outputs();
        do_push = iv && (model_q.size() < DEPTH) && !fl && !rst;
        do_pop  = ordy && (model_q.size() != 0) && !fl && !rst;
        @(posedge clk);
        if (rst || fl) begin
            model_q.delete();
        end else begin
            if (do_pop) void'(model_q.pop_front());
            if (do_push) model_q.push_back({pc, ins});
        end
        #1;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0; out_ready = 1'b0;
        @(posedge clk);
        #1;

        // Reset held two cycles with fetch offering data.
        step(1, 0, 1, 32'h40, 32'hdead0000, 0);
        step(1, 0, 1, 32'h44, 32'hdead0001, 1);

        // Fill with decode frozen, then offer a fifth pair.
        for (int i = 0; i < 4; i++) step(0, 0, 1, 32'(4 * i), 32'hA0 + 32'(i), 0);
        step(0, 0, 1, 32'd16, 32'hA4, 0);
        check("full_count", 64'(count), 64'd4);
        check("full_in_ready", 64'(in_ready), 64'd0);
        check("full_head_pc", 64'(out_pc), 64'd0);
        check("full_head_instr", 64'(out_instr), 64'hA0);

        // Drain in order.
        for (int i = 0; i < 4; i++) step(0, 0, 0, 32'h0, 32'h0, 1);
        step(0, 0, 0, 32'h0, 32'h0, 1);

        // Steady push+pop at count 2 across pointer wrap.
        next_pc = 32'h1000;
        for (int i = 0; i < 2; i++) begin
            step(0, 0, 1, next_pc, ~next_pc, 0);
            next_pc += 4;
        end
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 1, next_pc, ~next_pc, 1);
            next_pc += 4;
        end
        check("steady_count", 64'(count), 64'd2);
        check("steady_head_pc", 64'(out_pc), 64'(next_pc - 8));

        // Flush at count 3 together with a push.
        step(0, 0, 1, next_pc, ~next_pc, 0);
        step(0, 1, 1, 32'h100, 32'h1111, 1);
        check("flush_count", 64'(count), 64'd0);
        check("flush_valid", 64'(out_valid), 64'd0);
        step(0, 0, 1, 32'h200, 32'h2222, 0);
        check("post_flush_pc", 64'(out_pc), 64'h200);

        // Flush held several cycles with fetch offering data.
        for (int i = 0; i < 3; i++) step(0, 1, 1, 32'h300 + 32'(4 * i), 32'h3333, 1);
        step(0, 0, 0, 32'h0, 32'h0, 0);

        // Reset mid-stream with push and pop active.
        step(0, 0, 1, 32'h400, 32'h4000, 0);
        step(0, 0, 1, 32'h404, 32'h4004, 0);
        step(0, 0, 1, 32'h408, 32'h4008, 1);
        step(1, 0, 1, 32'h40c, 32'h400c, 1);
        check("reset_mid_count", 64'(count), 64'd0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 32'h500 + 32'(4 * i), 32'h5000 + 32'(i), 1);

        // Random traffic.
        next_pc = 32'h8000;
        for (int i = 0; i < 3000; i++) begin
            bit r, f, v, o;
            r = ($urandom_range(0, 99) < 2);
            f = ($urandom_range(0, 99) < 5);
            v = ($urandom_range(0, 99) < 70);
            o = ($urandom_range(0, 99) < 55);
            step(r, f, v, next_pc, $urandom, o);
            next_pc += 4;
        end
        step(0, 0, 0, 32'h0, 32'h0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
